// File: rtl/com_pkg.sv
// Shared definitions for the COM hub: register addresses, flag bit positions
// and the STATUS register layout.
package com_pkg;

    localparam logic [7:0] COM_ADDR_STATUS   = 8'h04;
    localparam logic [7:0] COM_ADDR_TXDATA   = 8'h05;
    localparam logic [7:0] COM_ADDR_LEDS     = 8'h06;
    localparam logic [7:0] COM_ADDR_SWITCHES = 8'h07;
    localparam logic [7:0] COM_ADDR_RXDATA   = 8'h08;
    localparam logic [7:0] COM_ADDR_IEN      = 8'h09;
    localparam logic [7:0] COM_ADDR_ISTAT    = 8'h0A;

    localparam int STAT_RX_NONEMPTY  = 0;
    localparam int STAT_IS_RECEIVING = 1;
    localparam int STAT_IS_TX        = 2;
    localparam int STAT_RX_FULL      = 3;
    localparam int STAT_RX_OVF       = 4;
    localparam int STAT_TX_OVF       = 5;

    localparam int ISTAT_RX_NONEMPTY = 0;
    localparam int ISTAT_RX_OVF      = 1;
    localparam int ISTAT_SW_CHANGE   = 2;

    typedef struct packed {
        logic [1:0] rsvd;
        logic       tx_ovf;
        logic       rx_ovf;
        logic       rx_full;
        logic       is_transmitting;
        logic       is_receiving;
        logic       rx_nonempty;
    } com_status_t;

endpackage

// File: rtl/com_rx_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop on a full FIFO frees the
// slot for a push in the same cycle.
module com_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart.sv
// 8N1 UART; one bit lasts 4*CLOCK_DIVIDE clocks. RX samples at bit centres
// after a double-flop synchroniser on the line.
module uart #(
    parameter int CLOCK_DIVIDE = 1302
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    input  logic       transmit,
    input  logic [7:0] tx_byte,
    output logic       received,
    output logic [7:0] rx_byte,
    output logic       is_receiving,
    output logic       is_transmitting
);

    localparam int CW = $clog2(4 * CLOCK_DIVIDE);
    localparam logic [CW-1:0] BIT_LAST  = CW'(4 * CLOCK_DIVIDE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(2 * CLOCK_DIVIDE - 1);
    localparam logic [CW-1:0] CNT_ONE   = 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    rx_state_t     rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bits, rx_bits_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic [7:0]    rx_byte_n;
    logic          received_n;
    logic [1:0]    rx_sync;
    logic          rx_s;

    tx_state_t     tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [3:0]    tx_bits, tx_bits_n;
    logic [9:0]    tx_shift, tx_shift_n;

    assign rx_s            = rx_sync[1];
    assign is_receiving    = (rx_state != R_IDLE);
    assign is_transmitting = (tx_state == T_SEND);
    assign tx              = tx_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            received <= 1'b0;
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bits  <= rx_bits_n;
            rx_shift <= rx_shift_n;
            rx_byte  <= rx_byte_n;
            received <= received_n;
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bits  <= tx_bits_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bits_n  = rx_bits;
        rx_shift_n = rx_shift;
        rx_byte_n  = rx_byte;
        received_n = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (!rx_s) begin
                    rx_state_n = R_START;
                    rx_cnt_n   = HALF_LAST;
                end
            end
            R_START: begin
                if (rx_cnt == '0) begin
                    // A start bit that is high again at its centre was a glitch.
                    if (!rx_s) begin
                        rx_state_n = R_DATA;
                        rx_cnt_n   = BIT_LAST;
                        rx_bits_n  = '0;
                    end else begin
                        rx_state_n = R_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            R_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_cnt_n   = BIT_LAST;
                    rx_bits_n  = rx_bits + 3'd1;
                    if (rx_bits == 3'd7) rx_state_n = R_STOP;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: begin
                if (rx_cnt == '0) begin
                    rx_state_n = R_IDLE;
                    if (rx_s) begin
                        received_n = 1'b1;
                        rx_byte_n  = rx_shift;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bits_n  = tx_bits;
        tx_shift_n = tx_shift;
        case (tx_state)
            T_IDLE: begin
                if (transmit) begin
                    tx_state_n = T_SEND;
                    tx_shift_n = {1'b1, tx_byte, 1'b0};
                    tx_cnt_n   = BIT_LAST;
                    tx_bits_n  = '0;
                end
            end
            default: begin
                if (tx_cnt == '0) begin
                    tx_shift_n = {1'b1, tx_shift[9:1]};
                    tx_cnt_n   = BIT_LAST;
                    tx_bits_n  = tx_bits + 4'd1;
                    if (tx_bits == 4'd9) tx_state_n = T_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/com_hub.sv
// Memory-mapped COM hub: LEDs, synchronised switches, UART with RX FIFO and a
// maskable level interrupt. Optional RX->TX echo is enabled by COM_LOOPBACK_EN.
module com_hub import com_pkg::*; #(
    parameter int CLOCK_DIVIDE = 1302,
    parameter int RX_DEPTH     = 8,
    parameter int LED_W        = 8,
    parameter int SW_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       addr,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             interrupt,
    output logic [LED_W-1:0] leds,
    input  logic [SW_W-1:0]  switches,
    output logic             uart_tx,
    input  logic             uart_rx
);

    logic       uart_received;
    logic [7:0] uart_rx_byte;
    logic       is_receiving;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       echo;

    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    logic       wr_status, wr_tx, wr_leds, wr_ien, wr_istat, rd_rx;
    logic       tx_ovf, rx_ovf, sw_change;
    logic       tx_ovf_set, rx_ovf_set;
    logic [2:0] ien;
    logic [2:0] istat;

    logic [SW_W-1:0] sw_meta, sw_sync, sw_prev;
    logic [7:0]      sw_ext, leds_ext, rd_mux;
    com_status_t     status;

    assign wr_status = wr_en && (addr == COM_ADDR_STATUS);
    assign wr_tx     = wr_en && (addr == COM_ADDR_TXDATA);
    assign wr_leds   = wr_en && (addr == COM_ADDR_LEDS);
    assign wr_ien    = wr_en && (addr == COM_ADDR_IEN);
    assign wr_istat  = wr_en && (addr == COM_ADDR_ISTAT);
    assign rd_rx     = rd_en && (addr == COM_ADDR_RXDATA);

    uart #(.CLOCK_DIVIDE(CLOCK_DIVIDE)) u_uart (
        .clk             (clk),
        .rst             (rst),
        .rx              (uart_rx),
        .tx              (uart_tx),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .received        (uart_received),
        .rx_byte         (uart_rx_byte),
        .is_receiving    (is_receiving),
        .is_transmitting (is_transmitting)
    );

    com_rx_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_received),
        .pop   (rd_rx),
        .din   (uart_rx_byte),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Echo owns the transmitter for the cycle it fires; a host byte then loses.
    always_comb begin
        echo     = 1'b0;
        transmit = 1'b0;
        tx_byte  = wr_data;
`ifdef COM_LOOPBACK_EN
        echo = uart_received && !is_transmitting;
`endif
        if (echo) begin
            transmit = 1'b1;
            tx_byte  = uart_rx_byte;
        end else if (wr_tx && !is_transmitting) begin
            transmit = 1'b1;
        end
    end

    assign tx_ovf_set = wr_tx && (is_transmitting || echo);
    // A full FIFO only loses the byte if no pop frees a slot this cycle.
    assign rx_ovf_set = uart_received && fifo_full && !rd_rx;

    assign istat = {sw_change, rx_ovf, !fifo_empty};

    always_comb begin
        status                 = '0;
        status.rx_nonempty     = !fifo_empty;
        status.is_receiving    = is_receiving;
        status.is_transmitting = is_transmitting;
        status.rx_full         = fifo_full;
        status.rx_ovf          = rx_ovf;
        status.tx_ovf          = tx_ovf;
    end

    always_comb begin
        sw_ext                = '0;
        sw_ext[SW_W-1:0]      = sw_sync;
        leds_ext              = '0;
        leds_ext[LED_W-1:0]   = leds;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            COM_ADDR_STATUS:   rd_mux = status;
            COM_ADDR_LEDS:     rd_mux = leds_ext;
            COM_ADDR_SWITCHES: rd_mux = sw_ext;
            COM_ADDR_RXDATA:   rd_mux = fifo_empty ? 8'h00 : fifo_head;
            COM_ADDR_IEN:      rd_mux = {5'b00000, ien};
            COM_ADDR_ISTAT:    rd_mux = {5'b00000, istat};
            default:           rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= 8'h00;
            interrupt <= 1'b0;
            leds      <= '0;
            ien       <= '0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            sw_change <= 1'b0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            sw_prev   <= '0;
        end else begin
            if (rd_en)   rd_data <= rd_mux;
            if (wr_leds) leds    <= wr_data[LED_W-1:0];
            if (wr_ien)  ien     <= wr_data[2:0];

            sw_meta <= switches;
            sw_sync <= sw_meta;
            sw_prev <= sw_sync;

            if (tx_ovf_set)
                tx_ovf <= 1'b1;
            else if (wr_status && wr_data[STAT_TX_OVF])
                tx_ovf <= 1'b0;

            if (rx_ovf_set)
                rx_ovf <= 1'b1;
            else if ((wr_status && wr_data[STAT_RX_OVF]) ||
                     (wr_istat && wr_data[ISTAT_RX_OVF]))
                rx_ovf <= 1'b0;

            if (sw_sync != sw_prev)
                sw_change <= 1'b1;
            else if (wr_istat && wr_data[ISTAT_SW_CHANGE])
                sw_change <= 1'b0;

            interrupt <= |(istat & ien);
        end
    end

endmodule

// File: tb/tb_com_hub.sv
// Directed bench for com_hub; build with COM_LOOPBACK_EN to exercise the echo path.
module tb_com_hub;

    localparam int CD  = 4;
    localparam int BIT = 4 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       interrupt;
    logic [7:0] leds;
    logic [3:0] switches = '0;
    logic       uart_tx;
    logic       uart_rx = 1'b1;

    int total  = 0;
    int passed = 0;

    com_hub #(.CLOCK_DIVIDE(CD), .RX_DEPTH(8), .LED_W(8), .SW_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .interrupt (interrupt),
        .leds      (leds),
        .switches  (switches),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic uart_send(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = frame[i];
            repeat (BIT - 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic capture_tx(input int bound, output logic [7:0] b, output logic ok);
        logic found;
        found = 1'b0; ok = 1'b0; b = '0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            repeat (BIT / 2) @(negedge clk);
            if (uart_tx === 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    repeat (BIT) @(negedge clk);
                    b[k] = uart_tx;
                end
                repeat (BIT) @(negedge clk);
                ok = (uart_tx === 1'b1);
            end
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data); else passed++;
        total++; if (interrupt !== 1'b0) $display("FAIL reset_interrupt got=%b exp=0", interrupt); else passed++;
        total++; if (uart_tx !== 1'b1) $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); else passed++;
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL reset_status got=%h exp=00", d); else passed++;
        bus_read(8'h06, d);
        total++; if (d !== 8'h00) $display("FAIL reset_leds got=%h exp=00", d); else passed++;
        bus_read(8'h0A, d);
        total++; if (d !== 8'h00) $display("FAIL reset_istat got=%h exp=00", d); else passed++;
        bus_read(8'h09, d);
        total++; if (d !== 8'h00) $display("FAIL reset_ien got=%h exp=00", d); else passed++;
    endtask

    task automatic test_leds;
        logic [7:0] d;
        bus_write(8'h06, 8'hA5);
        total++; if (leds !== 8'hA5) $display("FAIL leds_out got=%h exp=a5", leds); else passed++;
        bus_write(8'h00, 8'hFF);
        bus_read(8'h06, d);
        total++; if (d !== 8'hA5) $display("FAIL leds_readback got=%h exp=a5", d); else passed++;
        bus_read(8'h00, d);
        total++; if (d !== 8'h00) $display("FAIL unmapped_read got=%h exp=00", d); else passed++;
    endtask

    task automatic test_rx_basic;
        logic [7:0] d;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        for (int i = 0; i < 3; i++) uart_send(exp_b[i]);
        bus_read(8'h04, d);
        total++; if (d !== 8'h01) $display("FAIL rx_status_nonempty got=%h exp=01", d); else passed++;
        for (int i = 0; i < 3; i++) begin
            bus_read(8'h08, d);
            total++; if (d !== exp_b[i]) $display("FAIL rx_byte%0d got=%h exp=%h", i, d, exp_b[i]); else passed++;
        end
        bus_read(8'h08, d);
        total++; if (d !== 8'h00) $display("FAIL rx_empty_read got=%h exp=00", d); else passed++;
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL rx_status_empty got=%h exp=00", d); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] d0, d1, d;
        uart_send(8'h11);
        uart_send(8'h22);
        @(negedge clk);
        addr = 8'h08; rd_en = 1'b1;
        @(negedge clk);
        d0 = rd_data;
        @(negedge clk);
        d1 = rd_data;
        rd_en = 1'b0;
        total++; if (d0 !== 8'h11) $display("FAIL b2b_first got=%h exp=11", d0); else passed++;
        total++; if (d1 !== 8'h22) $display("FAIL b2b_second got=%h exp=22", d1); else passed++;
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL b2b_status got=%h exp=00", d); else passed++;
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int i = 0; i < 9; i++) uart_send(8'h10 + 8'(i));
        bus_read(8'h04, d);
        total++; if (d !== 8'h19) $display("FAIL ovf_status got=%h exp=19", d); else passed++;
        bus_read(8'h0A, d);
        total++; if (d !== 8'h03) $display("FAIL ovf_istat got=%h exp=03", d); else passed++;
        bus_write(8'h0A, 8'h02);
        bus_read(8'h0A, d);
        total++; if (d !== 8'h01) $display("FAIL ovf_istat_clr got=%h exp=01", d); else passed++;
        bus_read(8'h04, d);
        total++; if (d !== 8'h09) $display("FAIL ovf_status_clr got=%h exp=09", d); else passed++;
        for (int i = 0; i < 8; i++) begin
            bus_read(8'h08, d);
            total++; if (d !== 8'h10 + 8'(i)) $display("FAIL ovf_byte%0d got=%h exp=%h", i, d, 8'h10 + 8'(i)); else passed++;
        end
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL ovf_drained got=%h exp=00", d); else passed++;
    endtask

    task automatic test_tx;
        logic [7:0] b, d1, d2, d;
        logic ok, quiet;
        fork
            capture_tx(50, b, ok);
            begin
                bus_write(8'h05, 8'h55);
                bus_read(8'h04, d1);
                bus_write(8'h05, 8'h66);
                bus_read(8'h04, d2);
            end
        join
        total++; if (d1 !== 8'h04) $display("FAIL tx_busy_status got=%h exp=04", d1); else passed++;
        total++; if (d2 !== 8'h24) $display("FAIL tx_ovf_status got=%h exp=24", d2); else passed++;
        total++; if (!ok || b !== 8'h55) $display("FAIL tx_serial got=%h ok=%b exp=55 ok=1", b, ok); else passed++;
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) quiet = 1'b0;
        end
        total++; if (!quiet) $display("FAIL tx_dropped_byte got=line_active exp=idle"); else passed++;
        bus_write(8'h04, 8'h20);
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL tx_ovf_clr got=%h exp=00", d); else passed++;
    endtask

    task automatic test_sw_interrupt;
        logic [7:0] d;
        logic found;
        bus_write(8'h09, 8'h04);
        bus_read(8'h09, d);
        total++; if (d !== 8'h04) $display("FAIL ien_readback got=%h exp=04", d); else passed++;
        @(negedge clk);
        switches = 4'h5;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (interrupt === 1'b1) found = 1'b1;
        end
        total++; if (!found) $display("FAIL sw_irq_rise got=0 exp=1 within 4 cycles"); else passed++;
        bus_read(8'h0A, d);
        total++; if (d !== 8'h04) $display("FAIL sw_istat got=%h exp=04", d); else passed++;
        bus_read(8'h07, d);
        total++; if (d !== 8'h05) $display("FAIL sw_value got=%h exp=05", d); else passed++;
        bus_write(8'h0A, 8'h04);
        @(negedge clk);
        total++; if (interrupt !== 1'b0) $display("FAIL sw_irq_clear got=%b exp=0", interrupt); else passed++;
    endtask

    task automatic test_set_wins;
        logic [7:0] d;
        @(negedge clk);
        switches = 4'hA;
        @(negedge clk);
        @(negedge clk);
        addr = 8'h0A; wr_data = 8'h04; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        bus_read(8'h0A, d);
        total++; if (d !== 8'h04) $display("FAIL set_wins_istat got=%h exp=04", d); else passed++;
        bus_write(8'h0A, 8'h04);
        bus_read(8'h0A, d);
        total++; if (d !== 8'h00) $display("FAIL set_wins_clear got=%h exp=00", d); else passed++;
    endtask

    task automatic test_rx_interrupt;
        logic [7:0] d;
        bus_write(8'h09, 8'h01);
        uart_send(8'h5A);
        total++; if (interrupt !== 1'b1) $display("FAIL rx_irq_rise got=%b exp=1", interrupt); else passed++;
        bus_read(8'h08, d);
        total++; if (d !== 8'h5A) $display("FAIL rx_irq_byte got=%h exp=5a", d); else passed++;
        @(negedge clk);
        total++; if (interrupt !== 1'b0) $display("FAIL rx_irq_fall got=%b exp=0", interrupt); else passed++;
        bus_write(8'h09, 8'h00);
    endtask

    task automatic test_loopback;
        logic [7:0] b, d;
        logic ok;
`ifdef COM_LOOPBACK_EN
        fork
            capture_tx(400, b, ok);
            uart_send(8'h7E);
        join
        total++; if (!ok || b !== 8'h7E) $display("FAIL echo_serial got=%h ok=%b exp=7e ok=1", b, ok); else passed++;
`else
        ok = 1'b1; b = 8'h00;
        fork
            for (int i = 0; i < 330; i++) begin
                @(negedge clk);
                if (uart_tx !== 1'b1) ok = 1'b0;
            end
            uart_send(8'h7E);
        join
        total++; if (!ok) $display("FAIL no_echo got=line_active exp=idle byte=%h", b); else passed++;
`endif
        bus_read(8'h08, d);
        total++; if (d !== 8'h7E) $display("FAIL echo_fifo got=%h exp=7e", d); else passed++;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        bus_write(8'h06, 8'h3C);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT - 1) @(negedge clk);
        @(negedge clk);
        uart_rx = 1'b1;
        bus_read(8'h04, d);
        total++; if (d !== 8'h02) $display("FAIL mid_is_receiving got=%h exp=02", d); else passed++;
        repeat (BIT - 2) @(negedge clk);
        uart_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        #1;
        total++; if (leds !== 8'h00) $display("FAIL async_rst_leds got=%h exp=00", leds); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL async_rst_rd_data got=%h exp=00", rd_data); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        bus_read(8'h04, d);
        total++; if (d !== 8'h00) $display("FAIL mid_status_after got=%h exp=00", d); else passed++;
        bus_read(8'h08, d);
        total++; if (d !== 8'h00) $display("FAIL mid_no_partial got=%h exp=00", d); else passed++;
        total++; if (uart_tx !== 1'b1) $display("FAIL mid_uart_tx got=%b exp=1", uart_tx); else passed++;
    endtask

    initial begin
        test_reset();
        test_leds();
        test_rx_basic();
        test_back_to_back();
        test_overflow();
        test_tx();
        test_sw_interrupt();
        test_set_wins();
        test_rx_interrupt();
        test_loopback();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
